// File: rtl/rf_writeback_unit_if.sv
// Bundle of issue, result-source and register-file write signals for the writeback unit.
// The master side is decode plus the result sources. The slave side is the writeback unit.
interface rf_writeback_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ready;

  logic          a_valid;
  logic [4:0]    a_rd;
  logic [63:0]   a_data;
  logic          a_ready;

  logic          m_valid;
  logic [4:0]    m_rd;
  logic [63:0]   m_data;
  logic          m_ready;

  logic          we;
  logic [4:0]    wr_addr;
  logic [63:0]   wr_data;
  logic [31:0]   pending;
  logic [CW-1:0] fifo_count;

  modport master (
    output issue_valid, issue_rd,
    output a_valid, a_rd, a_data,
    output m_valid, m_rd, m_data,
    input  issue_ready, a_ready, m_ready,
    input  we, wr_addr, wr_data, pending, fifo_count
  );

  modport slave (
    input  issue_valid, issue_rd,
    input  a_valid, a_rd, a_data,
    input  m_valid, m_rd, m_data,
    output issue_ready, a_ready, m_ready,
    output we, wr_addr, wr_data, pending, fifo_count
  );
endinterface

// File: rtl/rf_writeback_unit.sv
// Register-file write front end. It merges ALU and memory/multiply results and buffers the M results.
// It stops M from starving and keeps a per-register pending scoreboard for decode.
module rf_writeback_unit #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  rf_writeback_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [63:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    starve_cnt;
  logic [7:0]    starve_next;

  logic          fifo_empty;
  logic          fifo_full;
  logic          force_m;
  logic          a_win;
  logic          pop;
  logic          push;

  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [63:0]   sel_data;
  logic          we_next;

  logic          we_q;
  logic [4:0]    wr_addr_q;
  logic [63:0]   wr_data_q;
  logic [31:0]   pending_q;
  logic [31:0]   pending_next;
  logic          issue_fire;

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    force_m    = (starve_cnt == STARVE_MAX) && !fifo_empty;
    a_win      = bus.a_valid && !force_m;
    pop        = !fifo_empty && (force_m || !bus.a_valid);
    push       = bus.m_valid && !fifo_full;
    issue_fire = bus.issue_valid && !pending_q[bus.issue_rd];
  end

  // A has priority unless M has been starved. A write to x0 is consumed but not enabled.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (a_win) begin
      sel_valid = 1'b1;
      sel_rd    = bus.a_rd;
      sel_data  = bus.a_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end
    we_next = sel_valid && (sel_rd != 5'd0);
  end

  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || pop)
      starve_next = '0;
    else if (a_win && (starve_cnt != STARVE_MAX))
      starve_next = starve_cnt + 8'd1;
  end

  // Issue and completion never hit the same register in one cycle, so the order here does not matter.
  always_comb begin
    pending_next = pending_q;
    if (we_next)
      pending_next[sel_rd] = 1'b0;
    if (issue_fire && (bus.issue_rd != 5'd0))
      pending_next[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.m_rd;
      fifo_data[wr_ptr] <= bus.m_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      starve_cnt <= starve_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_next;
      pending_q <= pending_next;
      if (sel_valid) begin
        wr_addr_q <= sel_rd;
        wr_data_q <= sel_data;
      end
    end
  end

  assign bus.issue_ready = !pending_q[bus.issue_rd];
  assign bus.a_ready     = !force_m;
  assign bus.m_ready     = !fifo_full;
  assign bus.we          = we_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.pending     = pending_q;
  assign bus.fifo_count  = count;
endmodule
